dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: 64x32 RAM behind a 4-entry store buffer, 2-edge loads.
// Define DMEM_FWD_EN to forward buffered stores to loads instead of flushing first.
module dmem_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rdvalid,
    output logic        stall,
    output logic        misalign,
    output logic [2:0]  sb_count
);

`ifdef DMEM_FWD_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  count_q;
    logic [1:0]  head_q, tail_q;
    logic [5:0]  raddr_q, raddr_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q;
    logic        wr_done_q, wr_done_d;

    logic [31:0] ram_q [64];
    logic [5:0]  fifo_idx_q [4];
    logic [31:0] fifo_dat_q [4];

    logic        aligned;
    logic        wr_req;
    logic        rd_req;
    logic        bad_req;
    logic [5:0]  idx;
    logic        sb_full;
    logic        sb_empty;
    logic        enq;
    logic        drain;
    logic        stall_c;
    logic [31:0] rdata_sel;
    logic        unused_addr;

    assign aligned     = (ALUout[1:0] == 2'b00);
    assign wr_req      = MemWrite & aligned;
    assign rd_req      = MemRead & aligned;
    assign bad_req     = (MemWrite | MemRead) & ~aligned;
    assign idx         = ALUout[7:2];
    assign unused_addr = ^ALUout[31:8];

    assign sb_full  = (count_q == 3'd4);
    assign sb_empty = (count_q == 3'd0);
    assign drain    = !sb_empty && (state_q != READ);

    // Youngest matching buffered store wins over RAM.
    always_comb begin
        rdata_sel = ram_q[raddr_q];
`ifdef DMEM_FWD_EN
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < count_q) &&
                (fifo_idx_q[head_q + 2'(i)] == raddr_q)) begin
                rdata_sel = fifo_dat_q[head_q + 2'(i)];
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        wr_done_d = 1'b0;
        enq       = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            IDLE: begin
                // wr_done_q marks a combined request whose store already went in
                if (wr_req && !(rd_req && wr_done_q)) begin
                    enq       = !sb_full;
                    stall_c   = sb_full || rd_req;
                    wr_done_d = rd_req && !sb_full;
                end else if (rd_req) begin
`ifdef DMEM_FWD_EN
                    state_d = READ;
                    raddr_d = idx;
`else
                    if (sb_empty) begin
                        state_d = READ;
                        raddr_d = idx;
                    end else begin
                        state_d = FLUSH;
                        stall_c = 1'b1;
                    end
`endif
                end
            end
            READ: begin
                stall_c  = wr_req || rd_req;
                state_d  = IDLE;
                rvalid_d = 1'b1;
                rdata_d  = rdata_sel;
            end
`ifndef DMEM_FWD_EN
            FLUSH: begin
                if (!rd_req) begin
                    state_d = IDLE;
                    stall_c = wr_req;
                end else if (sb_empty) begin
                    state_d = READ;
                    raddr_d = idx;
                end else begin
                    stall_c = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            raddr_q    <= 6'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            wr_done_q <= wr_done_d;
            if (bad_req) begin
                misalign_q <= 1'b1;
            end
            if (enq) begin
                tail_q <= tail_q + 2'd1;
            end
            if (drain) begin
                head_q <= head_q + 2'd1;
            end
            count_q <= count_q + {2'b00, enq} - {2'b00, drain};
        end
    end

    // Storage arrays hold no reset; pointers alone define buffer contents.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_idx_q[tail_q] <= idx;
            fifo_dat_q[tail_q] <= writedata;
        end
        if (drain) begin
            ram_q[fifo_idx_q[head_q]] <= fifo_dat_q[head_q];
        end
    end

    assign readdata = rdata_q;
    assign rdvalid  = rvalid_q;
    assign stall    = stall_c & reset;
    assign misalign = misalign_q;
    assign sb_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a flat word-memory model.
// Works with or without DMEM_FWD_EN.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ALUout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        rdvalid;
    logic        stall;
    logic        misalign;
    logic [2:0]  sb_count;

    int nassert = 0;
    int nfail   = 0;

    // Architectural memory: a store is visible as soon as it is accepted.
    logic [31:0] model [64];

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ALUout    (ALUout),
        .writedata (writedata),
        .readdata  (readdata),
        .rdvalid   (rdvalid),
        .stall     (stall),
        .misalign  (misalign),
        .sb_count  (sb_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            output int ns, output logic [2:0] cnt);
        int n;
        n         = 0;
        MemWrite  = 1'b1;
        ALUout    = a;
        writedata = d;
        #1;
        while (stall === 1'b1 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("store_accept", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        cnt      = sb_count;
        model[a[7:2]] = d;
        ns = n;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a,
                           output int ns);
        int n;
        n       = 0;
        MemRead = 1'b1;
        ALUout  = a;
        #1;
        while (stall === 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("load_accept", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        chk("load_early_rdvalid", {31'b0, rdvalid}, 32'd0);
        chk("load_early_rdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        chk("load_rdvalid", {31'b0, rdvalid}, 32'd1);
        chk(tag, readdata, model[a[7:2]]);
        @(posedge clk);
        #1;
        chk("rdvalid_one_cycle", {31'b0, rdvalid}, 32'd0);
        chk("rdata_zero_after", readdata, 32'd0);
        ns = n;
    endtask

    task automatic do_combo(input logic [31:0] a, input logic [31:0] d);
        int n;
        n         = 0;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        ALUout    = a;
        writedata = d;
        #1;
        chk("combo_read_stalled", {31'b0, stall}, 32'd1);
        model[a[7:2]] = d;
        while (stall === 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("combo_accept", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        @(posedge clk);
        #1;
        chk("combo_rdvalid", {31'b0, rdvalid}, 32'd1);
        chk("combo_rdata", readdata, d);
        idle(1);
    endtask

    initial begin
        int          ns;
        int          ns5;
        logic [2:0]  cnt;
        logic [2:0]  max_cnt;
        logic [31:0] a;
        logic [31:0] d;
        int          op;

        reset     = 1'b1;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        ALUout    = 32'd0;
        writedata = 32'd0;
        #2;
        reset = 1'b0;
        #3;
        chk("rst_rdvalid", {31'b0, rdvalid}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_sb_count", {29'b0, sb_count}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);

        for (int i = 0; i < 64; i++) begin
            do_store({24'h0, 6'(i), 2'b00}, $urandom, ns, cnt);
        end
        idle(2);

        // single store, then load after two idle cycles
        do_store(32'h10, 32'hDEADBEEF, ns, cnt);
        chk("st_count_one", {29'b0, cnt}, 32'd1);
        idle(2);
        chk("st_drained", {29'b0, sb_count}, 32'd0);
        do_load("ld_deadbeef", 32'h10, ns);

        // five back-to-back stores
        max_cnt = 3'd0;
        ns5     = 0;
        for (int i = 0; i < 5; i++) begin
            do_store(32'(i * 4), 32'hA0000000 + 32'(i), ns, cnt);
            if (cnt > max_cnt) max_cnt = cnt;
            if (i == 4) ns5 = ns;
        end
        chk("b2b_count_le4", {31'b0, (max_cnt <= 3'd4)}, 32'd1);
        chk("b2b_st5_stall_le1", {31'b0, (ns5 <= 1)}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_load("b2b_readback", 32'(i * 4), ns);
        end

        // same word overwritten, then loaded immediately
        do_store(32'h20, 32'h11111111, ns, cnt);
        do_store(32'h20, 32'h22222222, ns, cnt);
        do_load("ld_youngest", 32'h20, ns);
`ifdef DMEM_FWD_EN
        chk("fwd_no_stall", ns, 32'd0);
`else
        chk("flush_stalls", {31'b0, (ns > 0)}, 32'd1);
`endif

        // misaligned store is dropped
        idle(2);
        MemWrite  = 1'b1;
        ALUout    = 32'h06;
        writedata = 32'hBADBAD00;
        #1;
        chk("mis_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_no_enq", {29'b0, sb_count}, 32'd0);
        do_load("mis_word1_kept", 32'h04, ns);
        chk("mis_sticky", {31'b0, misalign}, 32'd1);

        // upper address bits alias
        do_store(32'h104, 32'hCAFEF00D, ns, cnt);
        do_load("alias_read", 32'h04, ns);
        chk("alias_value", readdata === 32'h0 ? model[1] : 32'h0, 32'hCAFEF00D);

        do_combo(32'h48, 32'h0BADCAFE);

        for (int k = 0; k < 60; k++) begin
            op = int'($urandom_range(0, 10));
            a  = $urandom;
            a[1:0] = 2'b00;
            d  = $urandom;
            if (op <= 4) begin
                do_store(a, d, ns, cnt);
                chk("rnd_count_le4", {31'b0, (cnt <= 3'd4)}, 32'd1);
            end else if (op <= 8) begin
                do_load("rnd_load", a, ns);
            end else if (op == 9) begin
                do_combo(a, d);
            end else begin
                a[1:0] = 2'($urandom_range(1, 3));
                MemRead = 1'b1;
                ALUout  = a;
                #1;
                chk("rnd_mis_stall", {31'b0, stall}, 32'd0);
                @(posedge clk);
                #1;
                MemRead = 1'b0;
                chk("rnd_mis_flag", {31'b0, misalign}, 32'd1);
            end
            idle(int'($urandom_range(0, 2)));
        end

        // reset during READ aborts the load
        idle(3);
        MemRead = 1'b1;
        ALUout  = 32'h10;
        #1;
        chk("abort_accept", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_rdvalid", {31'b0, rdvalid}, 32'd0);
        chk("abort_readdata", readdata, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_misalign", {31'b0, misalign}, 32'd0);
        chk("abort_sb_count", {29'b0, sb_count}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("abort_no_pulse", {31'b0, rdvalid}, 32'd0);
        do_load("abort_word4_kept", 32'h10, ns);

        // undrained store is discarded by reset
        do_store(32'h30, 32'h12345678, ns, cnt);
        idle(2);
        MemWrite  = 1'b1;
        ALUout    = 32'h30;
        writedata = 32'h55AA55AA;
        #1;
        chk("discard_accept", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        chk("discard_pending", {29'b0, sb_count}, 32'd1);
        reset = 1'b0;
        #1;
        chk("discard_cleared", {29'b0, sb_count}, 32'd0);
        idle(1);
        reset = 1'b1;
        idle(1);
        do_load("discard_old_value", 32'h30, ns);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
